// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART TX peripheral
// Contents: register window base, register offsets, STATUS/CTRL bit positions,
// transmit FSM state type.
package uart_pkg;

  localparam logic [31:0] UART_BASE = 32'hFFFF0020;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 4;

  localparam int CTRL_IRQ_EN_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_periph_if.sv
// rtl/uart_tx_periph_if.sv - core MMIO store/load bus shared by the peripherals
// Signals: address (byte address), write_data, write_enable (window-qualified
// store strobe), read_data (combinational read of the addressed register).
// master = core side, slave = peripheral side.
interface uart_tx_periph_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data;

  modport master (output address, output write_data, output write_enable, input read_data);
  modport slave  (input address, input write_data, input write_enable, output read_data);
endinterface

// File: rtl/uart_tx_periph_fifo.sv
// rtl/uart_tx_periph_fifo.sv - synchronous FIFO holding queued TX bytes
// Ports: clk, rst (async active-low), push/wdata (ignored when full),
// pop (ignored when empty), rdata (head entry), full, empty, count.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // full is the pre-edge value, so a push on a full FIFO is dropped even
  // when a pop happens on the same edge
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Ports: clk, rst (async active-low), bus (MMIO slave: DATA/STATUS/CTRL
// registers at address[3:2]), tx (serial out, idle high), interrupt
// (level: irq_en & FIFO empty & transmitter idle).
module uart_tx_periph
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_periph_if.slave  bus,
  output logic             tx,
  output logic             interrupt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t            state, next_state;
  logic [1:0]           offset;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 irq_en;
  logic                 overflow;
  logic [DIV_WIDTH-1:0] bit_div;
  logic [DIV_WIDTH-1:0] bit_timer;
  logic [3:0]           bit_idx;
  logic [7:0]           shift_reg;
  logic                 bit_end;
  logic                 busy;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]           fifo_head;
  logic [CW-1:0]        fifo_count;
  logic [31:0]          count_ext;
  logic [3:0]           count_disp;
  logic                 unused_bits;

  assign offset      = bus.address[3:2];
  assign fifo_push   = bus.write_enable & (offset == OFF_DATA);
  assign bit_end     = (bit_timer == bit_div - DIV_WIDTH'(1));
  assign busy        = (state != IDLE);
  assign interrupt   = irq_en & fifo_empty & ~busy;
  assign count_ext   = 32'(fifo_count);
  assign count_disp  = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign unused_bits = &{1'b0, bus.address[31:4], bus.address[1:0],
                         bus.write_data[31:17], count_ext[31:4]};

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (bus.write_data[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    tx         = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) next_state = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (bit_end && bit_idx == 4'd7) next_state = STOP;
      end
      STOP: begin
        if (bit_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bit timing: the divisor is captured at pop so CTRL writes only affect
  // the following frame; a zero divisor is stretched to one clock per bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_div   <= DIV_WIDTH'(1);
      bit_timer <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (fifo_pop) begin
      shift_reg <= fifo_head;
      bit_div   <= (divisor == '0) ? DIV_WIDTH'(1) : divisor;
      bit_timer <= '0;
      bit_idx   <= '0;
    end else if (state != IDLE) begin
      if (bit_end) begin
        bit_timer <= '0;
        if (state == DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + 4'd1;
        end
      end else begin
        bit_timer <= bit_timer + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor  <= DIV_WIDTH'(DEFAULT_DIV);
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else if (bus.write_enable) begin
      case (offset)
        OFF_DATA:   if (fifo_full) overflow <= 1'b1;
        OFF_STATUS: if (bus.write_data[STAT_OVF_BIT]) overflow <= 1'b0;
        OFF_CTRL: begin
          divisor <= bus.write_data[DIV_WIDTH-1:0];
          irq_en  <= bus.write_data[CTRL_IRQ_EN_BIT];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.read_data = '0;
    case (offset)
      OFF_STATUS: begin
        bus.read_data[STAT_FULL_BIT]  = fifo_full;
        bus.read_data[STAT_EMPTY_BIT] = fifo_empty;
        bus.read_data[STAT_BUSY_BIT]  = busy;
        bus.read_data[STAT_OVF_BIT]   = overflow;
        bus.read_data[STAT_CNT_LSB +: 4] = count_disp;
      end
      OFF_CTRL: begin
        bus.read_data[DIV_WIDTH-1:0]   = divisor;
        bus.read_data[CTRL_IRQ_EN_BIT] = irq_en;
      end
      default: bus.read_data = '0;
    endcase
  end

endmodule
